// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in IDLE. Misses optionally write back a dirty
// victim, then refill the line, then return to IDLE where the retried access hits.
module dcache_ctrl #(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         reset,      // asynchronous, active-low
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  input  logic         load,
  input  logic         store,
  input  logic         byte_acc,   // byte access select ("byte" is a reserved word)
  output logic [31:0]  rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 28 - IDX;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [TAGW-1:0]  tag_d  [LINES];
  logic [127:0]     data_q [LINES];
  logic [127:0]     data_d [LINES];

  logic [IDX-1:0]   idx;
  logic [TAGW-1:0]  tag;
  logic             req;
  logic             hit;
  logic             victim_dirty;
  logic [127:0]     line_cur;
  logic [127:0]     line_st;
  logic [31:0]      word_sel;
  logic [7:0]       byte_sel;
  logic             st_we;
  logic             rf_we;

  assign idx          = addr[3+IDX:4];
  assign tag          = addr[31:4+IDX];
  assign req          = load | store;
  assign line_cur     = data_q[idx];
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign word_sel     = line_cur[{addr[3:2], 5'b00000} +: 32];
  assign byte_sel     = line_cur[{addr[3:0], 3'b000} +: 8];

  // Merge the store data into the current line (byte lane or whole word)
  always_comb begin
    line_st = line_cur;
    if (byte_acc) begin
      line_st[{addr[3:0], 3'b000} +: 8] = wdata[7:0];
    end else begin
      line_st[{addr[3:2], 5'b00000} +: 32] = wdata;
    end
  end

  // State register; reset abandons any memory transaction at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = victim_dirty ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and line write enables; a load+store pair behaves as a store
  always_comb begin
    dhit      = 1'b0;
    rdata     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    st_we     = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        dhit = !req || hit;
        if (req && hit) begin
          if (store) begin
            st_we = 1'b1;
          end else begin
            rdata = byte_acc ? {{24{byte_sel[7]}}, byte_sel} : word_sel;
          end
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx, 4'b0000};
        mem_wdata = line_cur;
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr[31:4], 4'b0000};
        rf_we    = mem_ready;
      end
      default: begin
        dhit = 1'b0;
      end
    endcase
  end

  // Next line contents: refill installs a clean line, a store hit dirties it
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    for (int i = 0; i < LINES; i++) begin
      tag_d[i]  = tag_q[i];
      data_d[i] = data_q[i];
    end
    if (rf_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = tag;
      data_d[idx]  = mem_rdata;
    end else if (st_we) begin
      dirty_d[idx] = 1'b1;
      data_d[idx]  = line_st;
    end
  end

  // Valid and dirty bits are the only line state cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data storage keeps its contents across reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINES; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table, corner-case sequences and random accesses
// against a byte-level cache and memory model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         load;
  logic         store;
  logic         byte_acc;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  dcache_ctrl #(.LINES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .load      (load),
    .store     (store),
    .byte_acc  (byte_acc),
    .rdata     (rdata),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: per line valid/dirty/line-address and 16 bytes; memory image
  logic        ref_valid [4];
  logic        ref_dirty [4];
  logic [27:0] ref_laddr [4];
  logic [7:0]  ref_bytes [4][16];
  logic [127:0] mem_img [logic [27:0]];
  logic [127:0] last_wb_data;

  typedef struct {
    logic        ld;
    logic        st;
    logic        byt;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    int          exp_stalls;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [27:0] l);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = {4'hE, l[23:0], 4'(w)};
    return r;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] l);
    if (mem_img.exists(l)) return mem_img[l];
    return init_line(l);
  endfunction

  function automatic logic [127:0] pack_line(input int li);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = ref_bytes[li][b];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  // One memory phase of lat cycles; starts at a negedge, ends at the ready cycle's negedge
  task automatic mem_phase(input logic we, input logic [31:0] exp_addr,
                           input logic [127:0] line, input int lat, inout int stalls);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == lat);
      mem_rdata = we ? 128'h0 : line;
      @(negedge clk);
      chk("mem_req", mem_req, 1'b1);
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, exp_addr);
      if (we) begin
        chk("mem_wdata", mem_wdata, line);
        last_wb_data = mem_wdata;
      end
      if (!dhit) stalls++;
    end
  endtask

  // Full access: called just after a posedge, returns just after a posedge
  task automatic access(input logic ld, input logic st, input logic byt,
                        input logic [31:0] a, input logic [31:0] wd, input int lat,
                        output int stalls, output logic [31:0] rd);
    int          li;
    int          w;
    logic [27:0] line;
    logic        is_hit;
    logic [31:0] exp_rd;
    logic [127:0] rline;
    logic [7:0]  b;
    li     = int'(a[5:4]);
    line   = a[31:4];
    w      = int'(a[3:2]);
    is_hit = ref_valid[li] && (ref_laddr[li] == line);
    stalls = 0;
    load = ld; store = st; byte_acc = byt; addr = a; wdata = wd;
    @(negedge clk);
    if (!is_hit) begin
      chk("miss_dhit", dhit, 1'b0);
      chk("miss_no_req", mem_req, 1'b0);
      if (!dhit) stalls++;
      if (ref_valid[li] && ref_dirty[li]) begin
        mem_phase(1'b1, {ref_laddr[li], 4'h0}, pack_line(li), lat, stalls);
        mem_img[ref_laddr[li]] = pack_line(li);
      end
      rline = mem_line(line);
      mem_phase(1'b0, {line, 4'h0}, rline, lat, stalls);
      ref_valid[li] = 1'b1;
      ref_dirty[li] = 1'b0;
      ref_laddr[li] = line;
      for (int k = 0; k < 16; k++) ref_bytes[li][k] = rline[8*k +: 8];
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
    end
    exp_rd = 32'h0;
    if (ld && !st) begin
      if (byt) begin
        b = ref_bytes[li][int'(a[3:0])];
        exp_rd = 32'($signed(b));
      end else begin
        exp_rd = {ref_bytes[li][4*w+3], ref_bytes[li][4*w+2], ref_bytes[li][4*w+1], ref_bytes[li][4*w]};
      end
    end
    chk("hit_dhit", dhit, 1'b1);
    chk("rdata", rdata, exp_rd);
    chk("idle_mem_req", mem_req, 1'b0);
    chk("idle_mem_addr", mem_addr, 32'h0);
    rd = rdata;
    if (st) begin
      if (byt) begin
        ref_bytes[li][int'(a[3:0])] = wd[7:0];
      end else begin
        for (int k = 0; k < 4; k++) ref_bytes[li][4*w+k] = wd[8*k +: 8];
      end
      ref_dirty[li] = 1'b1;
    end
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0;
    $display("access ld=%0b st=%0b byte=%0b addr=%h wdata=%h lat=%0d stalls=%0d rdata=%h",
             ld, st, byt, a, wd, lat, stalls, rd);
  endtask

  initial begin
    int          stalls;
    logic [31:0] rd;
    logic        r_ld, r_st;
    int          op;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0,        3, 4, 32'hBBBBBBBB};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h106, 32'h80,       1, 0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h106, 32'h0,        1, 0, 32'hFFFFFF80};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h144, 32'h0,        2, 5, 32'h22222222};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h148, 32'h12345678, 1, 0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h148, 32'h0,        1, 0, 32'h12345678};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h210, 32'h0,        1, 2, 32'hE0000210};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h213, 32'h1FE,      1, 0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h213, 32'h0,        1, 0, 32'hFFFFFFFE};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h211, 32'h0,        1, 0, 32'h00000002};

    mem_img[28'h10] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    mem_img[28'h14] = 128'h44444444_33333333_22222222_11111111;
    last_wb_data = '0;
    model_reset();

    // Reset state
    reset = 1'b0; load = 1'b0; store = 1'b0; byte_acc = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_dhit", dhit, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      access(tbl[i].ld, tbl[i].st, tbl[i].byt, tbl[i].a, tbl[i].wd, tbl[i].lat, stalls, rd);
      chk("tbl_stalls", 128'(stalls), 128'(tbl[i].exp_stalls));
      chk("tbl_rdata", rd, tbl[i].exp_rd);
      if (i == 3) chk("wb_byte6", last_wb_data[55:48], 8'h80);
    end

    // Ten idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_dhit", dhit, 1'b1);
      chk("idle_req", mem_req, 1'b0);
    end
    @(posedge clk); #1;

    // Reset pulse during REFILL of a clean miss; dirty line at index 0 is lost
    load = 1'b1; addr = 32'h3A0;
    @(negedge clk);
    chk("rfl_miss_dhit", dhit, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rfl_req_high", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rfl_req_dropped", mem_req, 1'b0);
    chk("rfl_rdata", rdata, 32'h0);
    load = 1'b0;
    #1;
    chk("rfl_dhit_idle", dhit, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    access(1'b1, 1'b0, 1'b0, 32'h148, 32'h0, 2, stalls, rd);
    chk("post_rst_stalls", 128'(stalls), 128'(3));
    chk("post_rst_rdata", rd, 32'h33333333);

    // Random accesses against the model
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 3));
      r_ld = (op != 1);
      r_st = (op == 1) || (op == 2);
      access(r_ld, r_st, 1'($urandom_range(0, 1)),
             (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15)),
             $urandom, int'($urandom_range(1, 4)), stalls, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller answering the memory-stage load/store requests of the pipelined processor. It produces `dhit`, which the processor uses as the enable of its pipeline control registers: `dhit` low stalls the pipeline until the access completes. Misses are served over a line-wide request/ready handshake to main memory, preceded by a victim write-back when the line is dirty.

## Interface
- `LINES`, 4, number of cache lines; power of two, at least 2. `IDX = log2(LINES)`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset.
- `addr` in 32: byte address. Offset is `[3:0]`, index is `[3+IDX:4]`, tag is `[31:4+IDX]`.
- `wdata` in 32: store data; only `[7:0]` is used for byte stores.
- `load` in 1: load request.
- `store` in 1: store request.
- `byte` in 1: 1 = byte access, 0 = word access.
- `rdata` out 32: load data. Byte loads are sign-extended.
- `dhit` out 1: 1 = no request, or the request completes in this cycle.
- `mem_req` out 1: memory transaction request.
- `mem_we` out 1: 1 = line write-back, 0 = line refill.
- `mem_addr` out 32: line-aligned address; `[3:0] = 0`.
- `mem_wdata` out 128: victim line data.
- `mem_rdata` in 128: refill line data; valid while `mem_ready = 1`.
- `mem_ready` in 1: single-cycle pulse that completes the current transaction.

## Operation
- Per-line storage: `valid`, `dirty`, tag, and 128-bit data. Byte n of a line sits at bits `[8n+7:8n]`.
- Request = `load | store`. If both are asserted, the request is treated as a store.
- Hit = current line valid and tag equal.
- Word access selects word `addr[3:2]`; `addr[1:0]` is ignored. Byte access selects byte `addr[3:0]`.
- The initiator holds `addr`, `wdata`, `load`, `store` and `byte` stable while `dhit = 0`. The controller does not check this.
- FSM states:
  - **IDLE**
    - No request: `dhit = 1`.
    - Hit: `dhit = 1`, combinational `rdata`. A store writes its lanes and sets `dirty` at the edge.
    - Miss: `dhit = 0`. Go to WRITEBACK if the victim is valid and dirty, otherwise go to REFILL.
  - **WRITEBACK**
    - Drives `mem_req = 1`, `mem_we = 1`, `mem_addr = {victim tag, index, 4'b0}`, `mem_wdata = victim line`.
    - On `mem_ready`: go to REFILL.
  - **REFILL**
    - Drives `mem_req = 1`, `mem_we = 0`, `mem_addr = {addr[31:4], 4'b0}`.
    - On `mem_ready`: write `mem_rdata`, set tag, `valid = 1`, `dirty = 0`, then go to IDLE. The retried access then hits.
- `dhit = 0` in WRITEBACK and REFILL.
- `rdata` is 0 when there is no hit load.
- `mem_we`, `mem_addr` and `mem_wdata` are 0 when `mem_req = 0`.

## Timing
- Reset (`reset = 0`):
  - State goes to IDLE and every `valid` and `dirty` bit is cleared. Data and tags are not cleared.
  - `mem_req = 0`, `mem_we = 0`, `rdata = 0`.
  - `dhit` follows the IDLE rule, so `dhit = 1` with no request.
- Reset asserted mid-transaction abandons it immediately. `mem_req` drops asynchronously and dirty data is lost.
- Hit latency: 0 cycles; `dhit` and `rdata` are combinational in the request cycle.
- Clean miss:
  - Cycle 0: miss detected, `dhit = 0`.
  - Cycles 1..k: `mem_req = 1`.
  - `mem_ready` arrives in cycle k.
  - Cycle k+1: hit, `dhit = 1`.
- Dirty miss: the WRITEBACK phase adds its own request..ready span before REFILL begins. REFILL's `mem_req` is asserted in the cycle after the write-back's `mem_ready`.
- `mem_req` stays high and `mem_addr`/`mem_wdata` stay stable from assertion until the cycle in which `mem_ready = 1`, inclusive.
- `mem_ready` is ignored outside WRITEBACK and REFILL.
- A `mem_ready` that arrives in the same cycle `mem_req` rises is legal and completes the transaction.

## Test plan
- Cold load, word at `0x00000104`, `LINES = 4`, memory returns line `0x...DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA` with 3-cycle latency. Expected: `dhit = 0` for 4 cycles, a REFILL at `mem_addr = 0x100`, then `rdata = 0xBBBBBBBB` with `dhit = 1`.
- Store byte `0x80` to `0x00000106` on that resident line, then load byte from the same address. Expected: store has `dhit = 1` with no memory traffic; load returns `rdata = 0xFFFFFF80`; the line is dirty.
- Load `0x00000144`, which conflicts with index 0 of the dirty line. Expected: WRITEBACK with `mem_we = 1`, `mem_addr = 0x100`, and a `mem_wdata` byte 6 of `0x80`; then REFILL at `0x140`; then a hit.
- No request for 10 cycles. Expected: `dhit = 1`, `mem_req = 0` throughout.
- `load = 1` and `store = 1` together on a hit. Expected: the access performs a store; `rdata = 0`.
- `reset` pulsed low during REFILL. Expected: `mem_req` falls in the same cycle; after release a load to the previously resident line misses.
